// File: rtl/ghr_index_gen.sv
// gshare index generator for the BPU pattern history table.
// Keeps speculative/committed GHRs and an in-order checkpoint queue.
module ghr_index_gen #(
    parameter int ADDR_WIDTH = 9,
    parameter int GHR_WIDTH  = 9,
    parameter int CKPT_DEPTH = 4
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst_N,
    input  logic [63:0]           in_pc,
    input  logic                  in_predict_valid,
    input  logic                  in_prediction,
    input  logic                  in_resolve_valid,
    input  logic                  in_resolve_taken,
    input  logic                  in_flush,
    output logic [ADDR_WIDTH-1:0] out_pht_addr,
    output logic                  out_predict_ready,
    output logic                  out_train_valid,
    output logic [ADDR_WIDTH-1:0] out_train_addr,
    output logic                  out_train_taken,
    output logic                  out_mispredict,
    output logic [GHR_WIDTH-1:0]  out_spec_ghr
);

    localparam int PW = $clog2(CKPT_DEPTH);
    localparam int CW = PW + 1;

    logic [GHR_WIDTH-1:0]  spec_ghr;
    logic [GHR_WIDTH-1:0]  arch_ghr;
    logic [GHR_WIDTH-1:0]  spec_nxt;
    logic [ADDR_WIDTH-1:0] ent_addr [CKPT_DEPTH];
    logic                  ent_pred [CKPT_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  full;
    logic                  resolve_acc;
    logic                  mispredict_now;
    logic                  predict_acc;
    logic                  clear_q;
    logic                  unused_pc;

    assign unused_pc = ^{in_pc[63:ADDR_WIDTH+2], in_pc[1:0]};

    assign out_pht_addr = in_pc[ADDR_WIDTH+1:2]
                        ^ ADDR_WIDTH'(spec_ghr);

    assign full              = (count == CW'(CKPT_DEPTH));
    assign out_predict_ready = ~full;
    assign out_spec_ghr      = spec_ghr;

    assign resolve_acc = in_resolve_valid & (count != '0) & ~in_flush;

    assign mispredict_now = resolve_acc
                          & (in_resolve_taken != ent_pred[head]);

    assign predict_acc = in_predict_valid & ~full
                       & ~in_flush & ~mispredict_now;

    assign clear_q = in_flush | mispredict_now;

    // Next speculative history and occupancy, flush over mispredict.
    always_comb begin
        spec_nxt  = spec_ghr;
        count_nxt = count;
        unique case (1'b1)
            in_flush: begin
                spec_nxt  = arch_ghr;
                count_nxt = '0;
            end
            mispredict_now: begin
                spec_nxt  = {arch_ghr[GHR_WIDTH-2:0], in_resolve_taken};
                count_nxt = '0;
            end
            default: begin
                if (predict_acc)
                    spec_nxt = {spec_ghr[GHR_WIDTH-2:0], in_prediction};
                count_nxt = count + CW'(predict_acc) - CW'(resolve_acc);
            end
        endcase
    end

    // History registers and queue pointers.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            spec_ghr <= '0;
            arch_ghr <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            spec_ghr <= spec_nxt;
            count    <= count_nxt;
            if (resolve_acc)
                arch_ghr <= {arch_ghr[GHR_WIDTH-2:0], in_resolve_taken};
            if (clear_q) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (resolve_acc)
                    head <= head + PW'(1);
                if (predict_acc)
                    tail <= tail + PW'(1);
            end
        end
    end

    // Checkpoint storage: index and predicted direction per branch.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_pred[i] <= 1'b0;
            end
        end else if (predict_acc) begin
            ent_addr[tail] <= out_pht_addr;
            ent_pred[tail] <= in_prediction;
        end
    end

    // Registered training strobe and mispredict pulse.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            out_train_valid <= 1'b0;
            out_train_addr  <= '0;
            out_train_taken <= 1'b0;
            out_mispredict  <= 1'b0;
        end else begin
            out_train_valid <= resolve_acc;
            out_mispredict  <= mispredict_now;
            if (resolve_acc) begin
                out_train_addr  <= ent_addr[head];
                out_train_taken <= in_resolve_taken;
            end
        end
    end

endmodule

// File: tb/tb_ghr_index_gen.sv
// Bench for ghr_index_gen: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_ghr_index_gen;

    localparam int AW = 9;
    localparam int GW = 9;
    localparam int D  = 4;

    logic          in_Clk = 1'b0;
    logic          in_Rst_N = 1'b0;
    logic [63:0]   in_pc = '0;
    logic          in_predict_valid = 1'b0;
    logic          in_prediction = 1'b0;
    logic          in_resolve_valid = 1'b0;
    logic          in_resolve_taken = 1'b0;
    logic          in_flush = 1'b0;
    logic [AW-1:0] out_pht_addr;
    logic          out_predict_ready;
    logic          out_train_valid;
    logic [AW-1:0] out_train_addr;
    logic          out_train_taken;
    logic          out_mispredict;
    logic [GW-1:0] out_spec_ghr;

    ghr_index_gen #(
        .ADDR_WIDTH (AW),
        .GHR_WIDTH  (GW),
        .CKPT_DEPTH (D)
    ) dut (
        .in_Clk            (in_Clk),
        .in_Rst_N          (in_Rst_N),
        .in_pc             (in_pc),
        .in_predict_valid  (in_predict_valid),
        .in_prediction     (in_prediction),
        .in_resolve_valid  (in_resolve_valid),
        .in_resolve_taken  (in_resolve_taken),
        .in_flush          (in_flush),
        .out_pht_addr      (out_pht_addr),
        .out_predict_ready (out_predict_ready),
        .out_train_valid   (out_train_valid),
        .out_train_addr    (out_train_addr),
        .out_train_taken   (out_train_taken),
        .out_mispredict    (out_mispredict),
        .out_spec_ghr      (out_spec_ghr)
    );

    always #5 in_Clk = ~in_Clk;

    typedef struct {
        logic [AW-1:0] a;
        logic          p;
    } ent_t;

    ent_t          q[$];
    logic [GW-1:0] m_spec;
    logic [GW-1:0] m_arch;
    logic          m_tv;
    logic [AW-1:0] m_ta;
    logic          m_tt;
    logic          m_mis;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [AW-1:0] m_idx();
        return AW'(in_pc >> 2) ^ AW'(m_spec);
    endfunction

    task automatic model_reset();
        q.delete();
        m_spec = '0;
        m_arch = '0;
        m_tv   = 1'b0;
        m_ta   = '0;
        m_tt   = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic drive(input logic pv, input logic pr, input logic rv,
                         input logic rt, input logic fl,
                         input logic [63:0] pc);
        in_predict_valid = pv;
        in_prediction    = pr;
        in_resolve_valid = rv;
        in_resolve_taken = rt;
        in_flush         = fl;
        in_pc            = pc;
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 64'h100);
        in_Rst_N = 1'b0;
        #12;
        model_reset();
        @(negedge in_Clk);
        in_Rst_N = 1'b1;
        #1;
    endtask

    // Advance one clock; the model follows the behavioural rules.
    task automatic tick();
        logic [AW-1:0] idx;
        bit racc, mis, pacc;
        idx  = m_idx();
        racc = in_resolve_valid && (q.size() != 0) && !in_flush;
        mis  = 0;
        if (racc) mis = (in_resolve_taken != q[0].p);
        pacc = in_predict_valid && (q.size() < D) && !in_flush && !mis;
        @(posedge in_Clk);
        m_tv  = racc;
        m_mis = mis;
        if (racc) begin
            m_ta = q[0].a;
            m_tt = in_resolve_taken;
        end
        if (in_flush) begin
            m_spec = m_arch;
            q.delete();
        end else if (mis) begin
            m_arch = {m_arch[GW-2:0], in_resolve_taken};
            m_spec = m_arch;
            q.delete();
        end else begin
            if (racc) begin
                m_arch = {m_arch[GW-2:0], in_resolve_taken};
                void'(q.pop_front());
            end
            if (pacc) begin
                q.push_back('{a: idx, p: in_prediction});
                m_spec = {m_spec[GW-2:0], in_prediction};
            end
        end
        #1;
    endtask

    task automatic test_reset();
        in_Rst_N = 1'b0;
        #3;
        checks++;
        if (out_train_valid !== 1'b0 || out_mispredict !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses tv=%b mis=%b want 0", out_train_valid, out_mispredict);
        end
        checks++;
        if (out_train_addr !== '0 || out_train_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_train ta=%h tt=%b want 0", out_train_addr, out_train_taken);
        end
        checks++;
        if (out_spec_ghr !== '0 || out_predict_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ghr ghr=%h rdy=%b want 0/1", out_spec_ghr, out_predict_ready);
        end
        apply_reset();
    endtask

    task automatic test_index();
        apply_reset();
        drive(0, 0, 0, 0, 0, 64'h100);
        checks++;
        if (out_pht_addr !== 9'h040) begin
            errors++;
            $display("FAIL idx_first got %h want 040", out_pht_addr);
        end
        drive(1, 1, 0, 0, 0, 64'h100);
        tick();
        checks++;
        if (out_spec_ghr !== 9'h001) begin
            errors++;
            $display("FAIL idx_ghr got %h want 001", out_spec_ghr);
        end
        drive(0, 0, 0, 0, 0, 64'h103);
        checks++;
        if (out_pht_addr !== 9'h041) begin
            errors++;
            $display("FAIL idx_second got %h want 041", out_pht_addr);
        end
    endtask

    task automatic test_fill_and_resolve();
        logic [3:0] pat;
        pat = 4'b1011;
        apply_reset();
        for (int i = 3; i >= 0; i--) begin
            drive(1, pat[i], 0, 0, 0, 64'h100);
            tick();
        end
        checks++;
        if (out_spec_ghr !== 9'h00B || out_predict_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill ghr=%h rdy=%b want 00b/0", out_spec_ghr, out_predict_ready);
        end
        drive(1, 0, 0, 0, 0, 64'h200);
        tick();
        checks++;
        if (out_spec_ghr !== 9'h00B || out_predict_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_drop ghr=%h rdy=%b want 00b/0", out_spec_ghr, out_predict_ready);
        end
        drive(0, 0, 1, 1, 0, 64'h100);
        tick();
        checks++;
        if (out_train_valid !== 1'b1 || out_train_addr !== 9'h040 ||
            out_train_taken !== 1'b1 || out_mispredict !== 1'b0) begin
            errors++;
            $display("FAIL resolve_hit tv=%b ta=%h tt=%b mis=%b want 1/040/1/0",
                     out_train_valid, out_train_addr, out_train_taken, out_mispredict);
        end
        checks++;
        if (out_predict_ready !== 1'b1 || dut.arch_ghr !== 9'h001) begin
            errors++;
            $display("FAIL resolve_state rdy=%b arch=%h want 1/001",
                     out_predict_ready, dut.arch_ghr);
        end
        drive(0, 0, 0, 0, 0, 64'h100);
        tick();
        checks++;
        if (out_train_valid !== 1'b0 || out_train_addr !== 9'h040) begin
            errors++;
            $display("FAIL train_hold tv=%b ta=%h want 0/040", out_train_valid, out_train_addr);
        end
    endtask

    task automatic test_mispredict();
        apply_reset();
        drive(1, 1, 0, 0, 0, 64'h3C4);
        tick();
        drive(1, 1, 1, 0, 0, 64'h500);
        tick();
        checks++;
        if (out_mispredict !== 1'b1 || out_train_taken !== 1'b0 ||
            out_train_addr !== 9'h0F1) begin
            errors++;
            $display("FAIL mispredict mis=%b tt=%b ta=%h want 1/0/0f1",
                     out_mispredict, out_train_taken, out_train_addr);
        end
        checks++;
        if (out_spec_ghr !== 9'h000 || out_predict_ready !== 1'b1) begin
            errors++;
            $display("FAIL mis_repair ghr=%h rdy=%b want 000/1", out_spec_ghr, out_predict_ready);
        end
        drive(0, 0, 1, 1, 0, 64'h500);
        tick();
        checks++;
        if (out_mispredict !== 1'b0 || out_train_valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse mis=%b tv=%b want 0/0", out_mispredict, out_train_valid);
        end
    endtask

    task automatic test_flush();
        logic [2:0] pat;
        pat = 3'b011;
        apply_reset();
        drive(1, 1, 0, 0, 0, 64'h100);
        tick();
        drive(0, 0, 1, 1, 0, 64'h100);
        tick();
        for (int i = 2; i >= 0; i--) begin
            drive(1, pat[i], 0, 0, 0, 64'h40 * i);
            tick();
        end
        checks++;
        if (out_spec_ghr !== 9'h00B) begin
            errors++;
            $display("FAIL flush_pre ghr=%h want 00b", out_spec_ghr);
        end
        drive(1, 1, 1, 0, 1, 64'h100);
        tick();
        checks++;
        if (out_train_valid !== 1'b0 || out_mispredict !== 1'b0 ||
            out_spec_ghr !== 9'h001) begin
            errors++;
            $display("FAIL flush tv=%b mis=%b ghr=%h want 0/0/001",
                     out_train_valid, out_mispredict, out_spec_ghr);
        end
        drive(0, 0, 1, 0, 0, 64'h100);
        tick();
        checks++;
        if (out_train_valid !== 1'b0 || out_spec_ghr !== 9'h001) begin
            errors++;
            $display("FAIL empty_resolve tv=%b ghr=%h want 0/001",
                     out_train_valid, out_spec_ghr);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1, 1, 0, 0, 0, 64'h100);
        tick();
        drive(0, 0, 1, 1, 0, 64'h100);
        tick();
        checks++;
        if (out_train_valid !== 1'b1 || out_spec_ghr !== 9'h001) begin
            errors++;
            $display("FAIL areset_pre tv=%b ghr=%h want 1/001", out_train_valid, out_spec_ghr);
        end
        drive(0, 0, 0, 0, 0, 64'h100);
        in_Rst_N = 1'b0;
        #1;
        checks++;
        if (out_train_valid !== 1'b0 || out_train_addr !== '0 ||
            out_train_taken !== 1'b0 || out_spec_ghr !== '0) begin
            errors++;
            $display("FAIL areset tv=%b ta=%h tt=%b ghr=%h want all 0",
                     out_train_valid, out_train_addr, out_train_taken, out_spec_ghr);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic rt;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            rt = 1'($urandom_range(0, 1));
            if (q.size() != 0 && $urandom_range(0, 99) < 75) rt = q[0].p;
            drive($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 45, rt,
                  $urandom_range(0, 99) < 4, {$urandom, $urandom});
            checks++;
            if (out_pht_addr !== m_idx() || out_predict_ready !== (q.size() != D)) begin
                errors++;
                $display("FAIL rnd_comb n=%0d idx=%h/%h rdy=%b/%b", n,
                         out_pht_addr, m_idx(), out_predict_ready, q.size() != D);
            end
            tick();
            checks++;
            if (out_spec_ghr !== m_spec || out_train_valid !== m_tv ||
                out_train_addr !== m_ta || out_train_taken !== m_tt ||
                out_mispredict !== m_mis) begin
                errors++;
                $display("FAIL rnd_seq n=%0d ghr=%h/%h tv=%b/%b ta=%h/%h tt=%b/%b mis=%b/%b",
                         n, out_spec_ghr, m_spec, out_train_valid, m_tv,
                         out_train_addr, m_ta, out_train_taken, m_tt,
                         out_mispredict, m_mis);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_index();
        test_fill_and_resolve();
        test_mispredict();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghr_index_gen.md
Name: ghr_index_gen

Overview:
Upstream stage of the 2-bit-counter pattern history table in the BPU. It keeps a speculative and a committed global history register (GHR) and forms the gshare PHT index from the fetch PC and the speculative GHR. It holds an in-order checkpoint queue of in-flight predictions, so that resolution can produce the PHT training index/outcome and repair the GHR on a mispredict or flush.

Parameters:
ADDR_WIDTH, 9, PHT index width; must match the PHT's ADDR_WIDTH.
GHR_WIDTH, 9, global history length; GHR_WIDTH <= ADDR_WIDTH.
CKPT_DEPTH, 4, number of in-flight branch checkpoints; power of 2, >= 2.

Ports:
in_Clk  input  1  clock.
in_Rst_N  input  1  asynchronous, active-low reset.
in_pc  input  64  fetch PC of the branch being predicted.
in_predict_valid  input  1  a conditional branch is predicted this cycle.
in_prediction  input  1  PHT out_prediction for out_pht_addr this cycle.
in_resolve_valid  input  1  oldest in-flight branch resolves this cycle.
in_resolve_taken  input  1  actual direction of the resolving branch.
in_flush  input  1  pipeline flush (exception/redirect); discards all in-flight branches.
out_pht_addr  output  ADDR_WIDTH  combinational PHT index.
out_predict_ready  output  1  checkpoint queue not full.
out_train_valid  output  1  registered PHT training strobe.
out_train_addr  output  ADDR_WIDTH  registered index to train.
out_train_taken  output  1  registered outcome to train with.
out_mispredict  output  1  registered one-cycle mispredict pulse.
out_spec_ghr  output  GHR_WIDTH  current speculative GHR (debug/visibility).

Behaviour:
- Reset (asynchronous, in_Rst_N=0): spec_ghr=0, arch_ghr=0, head=tail=count=0. out_train_valid=0, out_train_addr=0, out_train_taken=0, out_mispredict=0. out_predict_ready=1.
- Index (combinational): out_pht_addr = in_pc[ADDR_WIDTH+1:2] XOR zero-extended spec_ghr. PC bits [1:0] are ignored.
- out_predict_ready = (count != CKPT_DEPTH).
- Predict accepted = in_predict_valid & out_predict_ready & ~in_flush & ~mispredict_now.
  - On accept: write {out_pht_addr, in_prediction} to entry[tail]; tail++ modulo CKPT_DEPTH.
  - spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], in_prediction}.
- Predict when full: ignored. No state change.
- Resolve accepted = in_resolve_valid & (count != 0) & ~in_flush. A resolve on an empty queue is ignored.
  - On accept: pop entry[head]; head++.
  - arch_ghr <= {arch_ghr[GHR_WIDTH-2:0], in_resolve_taken}.
  - Next cycle: out_train_valid=1, out_train_addr=entry.addr, out_train_taken=in_resolve_taken.
- mispredict_now = resolve accepted & (in_resolve_taken != entry[head].pred).
  - spec_ghr <= {arch_ghr[GHR_WIDTH-2:0], in_resolve_taken} (the new committed history).
  - All entries discarded: head=tail=count=0.
  - out_mispredict=1 next cycle, one cycle only.
- Correct resolve + accepted predict in the same cycle: pop and push both occur; count unchanged; spec_ghr shifts by the prediction.
- in_flush (highest priority): spec_ghr <= arch_ghr; queue cleared; no training strobe; no mispredict pulse. Any predict or resolve in that cycle is ignored.
- Priority order: reset > flush > mispredict > resolve/predict.
- count is updated as +1 on push and -1 on pop, net across the cycle. Pointers wrap modulo CKPT_DEPTH.
- Training outputs and out_mispredict are single-cycle pulses with 1-cycle latency from the resolve. out_train_addr and out_train_taken hold their values when not valid.
- Reset mid-operation clears everything immediately, without waiting for a clock edge.

Test Plan:
1. Reset, then in_pc=0x100, spec_ghr=0 -> out_pht_addr=0x040. Predict taken -> out_spec_ghr=0x001. Next out_pht_addr for PC 0x100 = 0x041.
2. Four predicts (1,0,1,1) with no resolve -> out_spec_ghr=0x00B, out_predict_ready=0. A fifth predict changes nothing.
3. From case 2, resolve taken (matches the first prediction) -> next cycle out_train_valid=1, out_train_addr=0x040, out_train_taken=1, out_mispredict=0. arch_ghr=0x001; ready returns to 1.
4. Predict taken at index A, then resolve not-taken -> out_mispredict pulses for 1 cycle, out_train_taken=0, out_spec_ghr=0x000 (arch history), queue empty. A predict issued in that same cycle is dropped.
5. Three predicts in flight, then in_flush together with in_resolve_valid -> no train strobe, queue empty, out_spec_ghr=arch_ghr.
6. Resolve on an empty queue -> no strobe, no GHR change. Assert in_Rst_N=0 mid-sequence -> all outputs zero without waiting for a clock edge.
